// File: rtl/melody_pkg.sv
// rtl/melody_pkg.sv - note codes, frequency table and melody for melody_player
package melody_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_C4   = 4'd1;
  localparam logic [3:0] NOTE_CS4  = 4'd2;
  localparam logic [3:0] NOTE_D4   = 4'd3;
  localparam logic [3:0] NOTE_DS4  = 4'd4;
  localparam logic [3:0] NOTE_E4   = 4'd5;
  localparam logic [3:0] NOTE_FS4  = 4'd6;
  localparam logic [3:0] NOTE_G4   = 4'd7;
  localparam logic [3:0] NOTE_A4   = 4'd8;
  localparam logic [3:0] NOTE_AS4  = 4'd9;
  localparam logic [3:0] NOTE_B4   = 4'd10;
  localparam logic [3:0] NOTE_C5   = 4'd11;
  localparam logic [3:0] NOTE_DS5  = 4'd12;
  localparam logic [3:0] NOTE_E5   = 4'd13;

  localparam int unsigned MAX_CODE   = 13;
  localparam int unsigned MELODY_LEN = 32;

  // Song table; steps past the end of the tune are rests.
  localparam logic [3:0] MELODY [MELODY_LEN] = '{
    NOTE_A4,  NOTE_REST, NOTE_E4,  NOTE_C5,
    NOTE_B4,  NOTE_A4,   NOTE_G4,  NOTE_FS4,
    NOTE_E4,  NOTE_D4,   NOTE_C4,  NOTE_REST,
    NOTE_E5,  NOTE_DS5,  NOTE_C5,  NOTE_B4,
    NOTE_A4,  NOTE_A4,   NOTE_AS4, NOTE_B4,
    NOTE_C5,  NOTE_REST, NOTE_E5,  NOTE_REST,
    NOTE_G4,  NOTE_E4,   NOTE_D4,  NOTE_C4,
    NOTE_REST, NOTE_REST, NOTE_REST, NOTE_REST
  };

  // Tone frequency in Hz for a note code; 0 means no tone.
  function automatic int unsigned note_freq(input int unsigned code);
    case (code)
      1:       return 262;
      2:       return 277;
      3:       return 294;
      4:       return 311;
      5:       return 330;
      6:       return 370;
      7:       return 392;
      8:       return 440;
      9:       return 466;
      10:      return 494;
      11:      return 523;
      12:      return 622;
      13:      return 659;
      default: return 0;
    endcase
  endfunction

  // Clocks per half period of the square wave; 0 means silence.
  function automatic int unsigned half_period(input int unsigned clk_hz, input int unsigned code);
    int unsigned f;
    f = note_freq(code);
    if (f == 0) return 0;
    return clk_hz / (2 * f);
  endfunction

  // Melody lookup that tolerates step indices beyond the stored song.
  function automatic logic [3:0] melody_at(input int unsigned idx);
    if (idx >= MELODY_LEN) return NOTE_REST;
    return MELODY[idx[4:0]];
  endfunction

endpackage

// File: rtl/melody_player_tone_gen.sv
// rtl/melody_player_tone_gen.sv - square-wave divider driven by a note code
module tone_gen
  import melody_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned NOTE_W = 4,
  parameter int unsigned DIV_W  = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NOTE_W-1:0] note_code,
  output logic              tone
);

  logic [DIV_W-1:0]  r_cnt;
  logic [NOTE_W-1:0] r_code;
  logic              r_tone;
  logic [DIV_W-1:0]  w_half;

  // Half-period lookup; each loop iteration folds to a constant.
  always_comb begin
    w_half = '0;
    for (int unsigned c = 1; c <= MAX_CODE; c++) begin
      if (32'(note_code) == c) w_half = DIV_W'(half_period(CLK_HZ, c));
    end
  end

  // Divider: disable, silence or a code change restart the wave low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_code <= '0;
      r_tone <= 1'b0;
    end else begin
      r_code <= note_code;
      if (!en || (note_code != r_code) || (w_half == '0)) begin
        r_cnt  <= '0;
        r_tone <= 1'b0;
      end else if (r_cnt == w_half - DIV_W'(1)) begin
        r_cnt  <= '0;
        r_tone <= ~r_tone;
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
    end
  end

  assign tone = r_tone;

endmodule

// File: rtl/melody_player.sv
// rtl/melody_player.sv - tempo-stepped melody sequencer with tone output
module melody_player
  import melody_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned N_STEPS    = 32,
  parameter int unsigned STEP_TICKS = 12500000,
  parameter int unsigned NOTE_W     = 4,
  parameter int unsigned DIV_W      = 17
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       updown,
  input  logic                       loop_en,
  output logic [$clog2(N_STEPS)-1:0] step_addr,
  output logic [NOTE_W-1:0]          note_code,
  output logic                       tone,
  output logic                       playing,
  output logic                       done
);

  localparam int unsigned SW = $clog2(N_STEPS);
  localparam int unsigned TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [SW-1:0] LAST_IDX  = SW'(N_STEPS - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);

  state_t            r_state, w_state_nxt;
  logic [SW-1:0]     r_step, w_step_nxt;
  logic [TW-1:0]     r_tick, w_tick_nxt;
  logic              r_dir, w_dir_nxt;
  logic              r_done, w_done_nxt;
  logic [NOTE_W-1:0] r_note;
  logic              w_tone_en;
  logic [SW-1:0]     w_first_start, w_final, w_wrap;

  assign w_first_start = updown ? '0 : LAST_IDX;
  assign w_final       = r_dir ? LAST_IDX : '0;
  assign w_wrap        = r_dir ? '0 : LAST_IDX;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: stop beats start, start beats the tempo tick; the divider
  // only runs on plain counting cycles so every step/state change restarts it.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_tick_nxt  = r_tick;
    w_dir_nxt   = r_dir;
    w_done_nxt  = 1'b0;
    w_tone_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_state_nxt = ST_PLAY;
          w_step_nxt  = w_first_start;
          w_tick_nxt  = '0;
          w_dir_nxt   = updown;
        end
      end
      ST_PLAY: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (start) begin
          w_step_nxt = w_first_start;
          w_tick_nxt = '0;
          w_dir_nxt  = updown;
        end else if (r_tick == TICK_LAST) begin
          w_tick_nxt = '0;
          if (r_step == w_final) begin
            if (loop_en) begin
              w_step_nxt = w_wrap;
            end else begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_step_nxt = r_dir ? r_step + SW'(1) : r_step - SW'(1);
          end
        end else begin
          w_tick_nxt = r_tick + TW'(1);
          w_tone_en  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Step, tempo, direction, done pulse and registered note lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step <= '0;
      r_tick <= '0;
      r_dir  <= 1'b1;
      r_done <= 1'b0;
      r_note <= '0;
    end else begin
      r_step <= w_step_nxt;
      r_tick <= w_tick_nxt;
      r_dir  <= w_dir_nxt;
      r_done <= w_done_nxt;
      r_note <= NOTE_W'(melody_at(32'(r_step)));
    end
  end

  tone_gen #(
    .CLK_HZ (CLK_HZ),
    .NOTE_W (NOTE_W),
    .DIV_W  (DIV_W)
  ) u_tone_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (w_tone_en),
    .note_code (r_note),
    .tone      (tone)
  );

  assign step_addr = r_step;
  assign note_code = r_note;
  assign playing   = (r_state == ST_PLAY);
  assign done      = r_done;

endmodule

// File: tb/tb_melody_player.sv
// tb/tb_melody_player.sv - directed self-checking bench for melody_player
module tb_melody_player;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_start, s_stop, s_updown, s_loop;
  logic [1:0] s_step;
  logic [3:0] s_note;
  logic       s_tone, s_playing, s_done;
  logic       b_start, b_stop, b_updown, b_loop;
  logic [4:0] b_step;
  logic [3:0] b_note;
  logic       b_tone, b_playing, b_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Small instance: 4 steps of 4 ticks, slow clock so A4 toggles every 2 cycles.
  melody_player #(
    .CLK_HZ(2000), .N_STEPS(4), .STEP_TICKS(4), .NOTE_W(4), .DIV_W(17)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .stop(s_stop),
    .updown(s_updown), .loop_en(s_loop), .step_addr(s_step),
    .note_code(s_note), .tone(s_tone), .playing(s_playing), .done(s_done)
  );

  // Default-clock instance for absolute tone period.
  melody_player u_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .stop(b_stop),
    .updown(b_updown), .loop_en(b_loop), .step_addr(b_step),
    .note_code(b_note), .tone(b_tone), .playing(b_playing), .done(b_done)
  );

  task automatic pulse_start();
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++; if (s_step !== 2'd0)  begin n_fail++; $display("FAIL reset_step got=%0d exp=0", s_step); end
    n_tests++; if (s_note !== 4'd0)  begin n_fail++; $display("FAIL reset_note got=%0d exp=0", s_note); end
    n_tests++; if (s_tone !== 1'b0)  begin n_fail++; $display("FAIL reset_tone got=%0b exp=0", s_tone); end
    n_tests++; if (s_playing !== 1'b0) begin n_fail++; $display("FAIL reset_playing got=%0b exp=0", s_playing); end
    n_tests++; if (s_done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got=%0b exp=0", s_done); end
    n_tests++; if (b_playing !== 1'b0) begin n_fail++; $display("FAIL reset_big_playing got=%0b exp=0", b_playing); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    s_updown = 1'b1; s_loop = 1'b1;
    pulse_start();
    repeat (8) @(negedge clk);
    n_tests++; if (s_step !== 2'd2) begin n_fail++; $display("FAIL midplay_step got=%0d exp=2", s_step); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (s_step !== 2'd0)  begin n_fail++; $display("FAIL async_step got=%0d exp=0", s_step); end
    n_tests++; if (s_note !== 4'd0)  begin n_fail++; $display("FAIL async_note got=%0d exp=0", s_note); end
    n_tests++; if (s_playing !== 1'b0) begin n_fail++; $display("FAIL async_playing got=%0b exp=0", s_playing); end
    n_tests++; if (s_tone !== 1'b0)  begin n_fail++; $display("FAIL async_tone got=%0b exp=0", s_tone); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++; if (s_playing !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got=%0b exp=0", s_playing); end
    n_tests++; if (s_note !== 4'd8) begin n_fail++; $display("FAIL post_reset_note got=%0d exp=8", s_note); end
  endtask

  task automatic test_ascending_oneshot();
    logic [3:0] exp_note [4];
    logic       exp_tone [8];
    exp_note = '{4'd8, 4'd0, 4'd5, 4'd11};
    exp_tone = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    s_updown = 1'b1; s_loop = 1'b0;
    pulse_start();
    for (int j = 0; j < 16; j++) begin
      n_tests++; if (s_step !== 2'(j / 4)) begin n_fail++; $display("FAIL asc_step j=%0d got=%0d exp=%0d", j, s_step, j / 4); end
      n_tests++; if (s_playing !== 1'b1 || s_done !== 1'b0) begin n_fail++; $display("FAIL asc_flags j=%0d playing=%0b done=%0b exp 1/0", j, s_playing, s_done); end
      if (j % 4 == 1) begin
        n_tests++; if (s_note !== exp_note[j / 4]) begin n_fail++; $display("FAIL asc_note j=%0d got=%0d exp=%0d", j, s_note, exp_note[j / 4]); end
      end
      if (j < 8) begin
        n_tests++; if (s_tone !== exp_tone[j]) begin n_fail++; $display("FAIL asc_tone j=%0d got=%0b exp=%0b", j, s_tone, exp_tone[j]); end
      end
      @(negedge clk);
    end
    n_tests++; if (s_done !== 1'b1) begin n_fail++; $display("FAIL asc_done_pulse got=%0b exp=1", s_done); end
    n_tests++; if (s_playing !== 1'b0) begin n_fail++; $display("FAIL asc_end_playing got=%0b exp=0", s_playing); end
    n_tests++; if (s_tone !== 1'b0) begin n_fail++; $display("FAIL asc_end_tone got=%0b exp=0", s_tone); end
    n_tests++; if (s_step !== 2'd3) begin n_fail++; $display("FAIL asc_end_step got=%0d exp=3", s_step); end
    @(negedge clk);
    n_tests++; if (s_done !== 1'b0) begin n_fail++; $display("FAIL asc_done_width got=%0b exp=0", s_done); end
  endtask

  task automatic test_descending_loop();
    s_updown = 1'b0; s_loop = 1'b1;
    pulse_start();
    for (int j = 0; j < 24; j++) begin
      n_tests++; if (s_step !== 2'(3 - ((j / 4) % 4))) begin n_fail++; $display("FAIL desc_step j=%0d got=%0d exp=%0d", j, s_step, 3 - ((j / 4) % 4)); end
      n_tests++; if (s_done !== 1'b0 || s_playing !== 1'b1) begin n_fail++; $display("FAIL desc_flags j=%0d done=%0b playing=%0b exp 0/1", j, s_done, s_playing); end
      if (j == 6) s_updown = 1'b1;
      @(negedge clk);
    end
    s_stop = 1'b1;
    @(negedge clk);
    s_stop = 1'b0;
    n_tests++; if (s_playing !== 1'b0) begin n_fail++; $display("FAIL stop_playing got=%0b exp=0", s_playing); end
    n_tests++; if (s_step !== 2'd1) begin n_fail++; $display("FAIL stop_step got=%0d exp=1", s_step); end
    n_tests++; if (s_tone !== 1'b0 || s_done !== 1'b0) begin n_fail++; $display("FAIL stop_tone_done tone=%0b done=%0b exp 0/0", s_tone, s_done); end
  endtask

  task automatic test_start_stop_same_cycle();
    s_updown = 1'b1; s_loop = 1'b0;
    pulse_start();
    repeat (9) @(negedge clk);
    n_tests++; if (s_step !== 2'd2) begin n_fail++; $display("FAIL ss_pre_step got=%0d exp=2", s_step); end
    s_start = 1'b1; s_stop = 1'b1;
    @(negedge clk);
    s_start = 1'b0; s_stop = 1'b0;
    n_tests++; if (s_playing !== 1'b0) begin n_fail++; $display("FAIL ss_playing got=%0b exp=0", s_playing); end
    n_tests++; if (s_step !== 2'd2) begin n_fail++; $display("FAIL ss_step got=%0d exp=2", s_step); end
    n_tests++; if (s_tone !== 1'b0) begin n_fail++; $display("FAIL ss_tone got=%0b exp=0", s_tone); end
    n_tests++; if (s_done !== 1'b0) begin n_fail++; $display("FAIL ss_done got=%0b exp=0", s_done); end
    @(negedge clk);
    n_tests++; if (s_done !== 1'b0 || s_playing !== 1'b0) begin n_fail++; $display("FAIL ss_after done=%0b playing=%0b exp 0/0", s_done, s_playing); end
  endtask

  task automatic test_restart();
    s_updown = 1'b1; s_loop = 1'b0;
    pulse_start();
    n_tests++; if (s_step !== 2'd0) begin n_fail++; $display("FAIL rs_first_step got=%0d exp=0", s_step); end
    repeat (13) @(negedge clk);
    n_tests++; if (s_step !== 2'd3) begin n_fail++; $display("FAIL rs_pre_step got=%0d exp=3", s_step); end
    s_updown = 1'b0;
    pulse_start();
    s_updown = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_tests++; if (s_step !== 2'd3 || s_playing !== 1'b1 || s_done !== 1'b0) begin n_fail++; $display("FAIL rs_hold j=%0d step=%0d playing=%0b done=%0b exp 3/1/0", j, s_step, s_playing, s_done); end
      @(negedge clk);
    end
    n_tests++; if (s_step !== 2'd2) begin n_fail++; $display("FAIL rs_desc_step got=%0d exp=2", s_step); end
    s_stop = 1'b1;
    @(negedge clk);
    s_stop = 1'b0;
  endtask

  task automatic test_tone_a4();
    int highs = 0;
    b_updown = 1'b1; b_loop = 1'b0;
    n_tests++; if (b_note !== 4'd8 || b_step !== 5'd0) begin n_fail++; $display("FAIL a4_pre note=%0d step=%0d exp 8/0", b_note, b_step); end
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    repeat (56817) begin
      @(negedge clk);
      if (b_tone !== 1'b0) highs++;
    end
    n_tests++; if (highs != 0) begin n_fail++; $display("FAIL a4_low_phase high_cycles=%0d exp=0", highs); end
    @(negedge clk);
    n_tests++; if (b_tone !== 1'b1) begin n_fail++; $display("FAIL a4_toggle got=%0b exp=1", b_tone); end
    b_stop = 1'b1;
    @(negedge clk);
    b_stop = 1'b0;
    n_tests++; if (b_tone !== 1'b0 || b_playing !== 1'b0) begin n_fail++; $display("FAIL a4_stop tone=%0b playing=%0b exp 0/0", b_tone, b_playing); end
  endtask

  initial begin
    rst_n = 1'b0;
    s_start = 1'b0; s_stop = 1'b0; s_updown = 1'b1; s_loop = 1'b0;
    b_start = 1'b0; b_stop = 1'b0; b_updown = 1'b1; b_loop = 1'b0;
    test_reset();
    test_ascending_oneshot();
    test_descending_loop();
    test_start_stop_same_cycle();
    test_restart();
    test_tone_a4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/melody_player.md
Name: melody_player

Overview:
- Parametrised successor of the microwave-music note mux.
- Plays a note sequence from a table. A tempo counter advances a step index, and each step selects a note code. A programmable divider turns that code into a square-wave tone for the buzzer.
- Adds start/stop control, a direction selection latched at start, optional looping, a done pulse and a clean silent output. All tone generation is driven from the single system clock; there are no per-note clock dividers.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz; used to compute half-period counts.
- N_STEPS, 32, number of steps in the melody table (at least 2).
- STEP_TICKS, 12500000, clocks per step (default is 250 ms).
- NOTE_W, 4, note code width.
- DIV_W, 17, tone divider counter width; must hold the largest half-period count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled; if high for a cycle, starts (or restarts) playback.
- stop  in  1  if high for a cycle, aborts playback.
- updown  in  1  1 = ascending step order, 0 = descending; latched at start.
- loop_en  in  1  1 = wrap at the end of the sequence, 0 = finish; sampled live.
- step_addr  out  $clog2(N_STEPS)  current step index.
- note_code  out  NOTE_W  code of the current step.
- tone  out  1  square-wave output to the buzzer.
- playing  out  1  high while in PLAY.
- done  out  1  one-cycle pulse when a non-looping sequence ends.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - State IDLE; step_addr = 0; note_code = 0; tone = 0; playing = 0; done = 0.
  - Tempo counter and divider counter are cleared; the latched direction is 1.
- FSM states: IDLE and PLAY.
- IDLE:
  - tone is held at 0; step_addr holds its last value.
  - If start = 1 and stop = 0, the next cycle enters PLAY. step_addr becomes 0 if updown = 1, otherwise N_STEPS-1. The tempo counter and the divider are cleared, and updown is latched.
- PLAY:
  - The tempo counter counts 0 to STEP_TICKS-1.
  - At the terminal count on a non-final step, step_addr moves by ±1 according to the latched direction, the tempo counter resets, and the divider is cleared with tone = 0 for that cycle.
  - Final step means N_STEPS-1 when ascending, 0 when descending.
  - At the terminal count on the final step:
    - loop_en = 1: wrap to the first step (0 or N_STEPS-1); there is no gap cycle.
    - loop_en = 0: go to IDLE, pulse done for 1 cycle, and drive tone to 0.
- stop = 1 in PLAY: go to IDLE on the next edge; tone is 0 from that edge on. stop has priority over start in the same cycle. No done pulse on stop.
- start = 1 in PLAY (with stop = 0): restart from the first step, relatching updown. Identical to a start from IDLE.
- note_code:
  - Registered.
  - Equals MELODY[step_addr], one cycle after step_addr changes.
  - tone follows one further cycle later.
- Tone generator:
  - Half-period count for code c is HALF[c] = CLK_HZ / (2 × freq[c]), integer-truncated.
  - The counter counts to HALF[c]-1, then toggles tone and reloads 0.
  - Code 0 (silence), or a code with no table entry, holds tone at 0 with the counter at 0.
  - A code change clears the counter and sets tone = 0.

Decomposition:
- Package melody_pkg holds:
  - Note code constants: 0 = silence, 1 = C4 262 Hz, 2 = C#4 277, 3 = D4 294, 4 = D#4 311, 5 = E4 330, 6 = F#4 370, 7 = G4 392, 8 = A4 440, 9 = A#4 466, 10 = B4 494, 11 = C5 523, 12 = D#5 622, 13 = E5 659.
  - The frequency table and the half-period function of CLK_HZ.
  - The MELODY constant array; entries beyond the defined song are 0.
- One sub-module, tone_gen, contains the divider: inputs clk, rst_n, en, note_code; output tone.

Test Plan:
1. Reset mid-PLAY at step 5: rst_n is low for 1 cycle. All outputs go 0 immediately (asynchronous), and the block stays in IDLE until start.
2. STEP_TICKS = 4, N_STEPS = 4, updown = 1, loop_en = 0, 1-cycle start pulse:
   - step_addr goes 0,1,2,3, each held 4 cycles.
   - done pulses once, 16 cycles after PLAY entry; playing then drops.
3. Same as 2 with updown = 0 and loop_en = 1: step_addr goes 3,2,1,0,3,2…; done never asserts; updown toggled mid-play has no effect.
4. Default CLK_HZ, MELODY step holding code 8 (A4): tone toggles every 56818 cycles. Code 0 step: tone stays 0 for the whole step.
5. start and stop both high in one cycle during PLAY at step 2: IDLE next cycle, tone = 0, step_addr holds 2, no done pulse.
6. start pulse in PLAY at step 3 with updown = 0: step_addr = N_STEPS-1 on the next cycle, the tempo counter restarts, and direction is descending.
